// File: rtl/issue_buffer_ss_pkg.sv
// Shared decode definitions for the superscalar issue buffer: opcode/funct
// constants, instruction field extraction and control-transfer classification.
package issue_pkg_ss;

    localparam logic [5:0] OP_SPECIAL    = 6'h00;
    localparam logic [5:0] OP_CTRL_FIRST = 6'h02;
    localparam logic [5:0] OP_CTRL_LAST  = 6'h07;
    localparam logic [5:0] OP_IMM_FIRST  = 6'h08;
    localparam logic [5:0] OP_IMM_LAST   = 6'h0F;
    localparam logic [5:0] OP_LOAD_WORD  = 6'h23;
    localparam logic [5:0] FUNCT_JR      = 6'h08;
    localparam logic [5:0] FUNCT_JALR    = 6'h09;

    typedef enum logic [1:0] {
        DEST_NONE,
        DEST_RD,
        DEST_RT
    } dest_sel_e;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_fields_t;

    typedef struct packed {
        logic [4:0] dest;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       is_ctrl;
    } slot_info_t;

    function automatic instr_fields_t fields_of(input logic [31:0] instr);
        return instr_fields_t'(instr);
    endfunction

    function automatic dest_sel_e dest_select(input logic [5:0] opcode);
        dest_sel_e sel;
        sel = DEST_NONE;
        if (opcode == OP_SPECIAL) begin
            sel = DEST_RD;
        end else if ((opcode >= OP_IMM_FIRST && opcode <= OP_IMM_LAST) ||
                     opcode == OP_LOAD_WORD) begin
            sel = DEST_RT;
        end
        return sel;
    endfunction

    // Register 0 doubles as "no destination", so it can never create a hazard.
    function automatic logic [4:0] dest_of(input instr_fields_t f);
        logic [4:0] dest;
        case (dest_select(f.opcode))
            DEST_RD: dest = f.rd;
            DEST_RT: dest = f.rt;
            default: dest = 5'd0;
        endcase
        return dest;
    endfunction

    function automatic logic is_ctrl_xfer(input instr_fields_t f);
        logic ctrl;
        ctrl = (f.opcode >= OP_CTRL_FIRST && f.opcode <= OP_CTRL_LAST) ||
               (f.opcode == OP_SPECIAL &&
                (f.funct == FUNCT_JR || f.funct == FUNCT_JALR));
        return ctrl;
    endfunction

endpackage

// File: rtl/issue_buffer_ss_if.sv
// Fetch, control and issue signals of the issue buffer grouped as one bus.
interface issue_buffer_ss_if #(
    parameter int WAYS  = 2,
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  stall;
    logic                  flush;
    logic [31:0]           redirect_pc;
    logic [31:0]           fetch_pc;
    logic [32*WAYS-1:0]    fetch_bundle;
    logic                  fetch_accept;
    logic [WAYS-1:0]       out_valid;
    logic [32*WAYS-1:0]    out_instr;
    logic [32*WAYS-1:0]    out_pc;
    logic [CNT_W-1:0]      count;

    modport slave (
        input  stall, flush, redirect_pc, fetch_bundle,
        output fetch_pc, fetch_accept, out_valid, out_instr, out_pc, count
    );

    modport master (
        output stall, flush, redirect_pc, fetch_bundle,
        input  fetch_pc, fetch_accept, out_valid, out_instr, out_pc, count
    );
endinterface

// File: rtl/issue_buffer_ss_slot_decode.sv
// Per-slot decoder: destination, sources and control-transfer flag of one word.
module slot_decode_ss
    import issue_pkg_ss::*;
(
    input  logic [31:0] instr,
    output slot_info_t  info
);
    instr_fields_t fields;

    // Split the word into fields and classify it for the hazard checks
    always_comb begin
        fields       = fields_of(instr);
        info.rs      = fields.rs;
        info.rt      = fields.rt;
        info.dest    = dest_of(fields);
        info.is_ctrl = is_ctrl_xfer(fields);
    end
endmodule

// File: rtl/issue_buffer_ss.sv
// Superscalar fetch/issue queue: captures WAYS-wide fetch bundles into a
// circular buffer and issues the longest hazard-free head prefix each cycle.
module issue_buffer_ss
    import issue_pkg_ss::*;
#(
    parameter int WAYS  = 2,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    issue_buffer_ss_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [WAYS-1:0]    out_valid_q, out_valid_d;
    logic [32*WAYS-1:0] out_instr_q, out_instr_d;
    logic [32*WAYS-1:0] out_pc_q, out_pc_d;
    logic [31:0]        instr_q [DEPTH];
    logic [31:0]        instr_d [DEPTH];
    logic [31:0]        pc_q [DEPTH];
    logic [31:0]        pc_d [DEPTH];

    logic               accept;
    logic               issue_blocked;
    logic [CNT_W-1:0]   issue_n;
    logic [CNT_W-1:0]   push_amt, pop_amt;
    logic [31:0]        head_instr [WAYS];
    logic [31:0]        head_pc [WAYS];
    slot_info_t         head_info [WAYS];

    // Gather the WAYS oldest queue entries as issue candidates
    always_comb begin
        for (int j = 0; j < WAYS; j++) begin
            head_instr[j] = instr_q[head_q + PTR_W'(j)];
            head_pc[j]    = pc_q[head_q + PTR_W'(j)];
        end
    end

    for (genvar g = 0; g < WAYS; g++) begin : g_decode
        slot_decode_ss u_decode (
            .instr (head_instr[g]),
            .info  (head_info[g])
        );
    end

    // Longest head prefix with no intra-group dependency and nothing after a branch
    always_comb begin
        issue_n       = '0;
        issue_blocked = 1'b0;
        for (int j = 0; j < WAYS; j++) begin
            if (!issue_blocked) begin
                if (CNT_W'(j) >= count_q) begin
                    issue_blocked = 1'b1;
                end
                for (int i = 0; i < j; i++) begin
                    if (head_info[i].is_ctrl) begin
                        issue_blocked = 1'b1;
                    end
                    if (head_info[i].dest != 5'd0 &&
                        (head_info[i].dest == head_info[j].rs ||
                         head_info[i].dest == head_info[j].rt ||
                         head_info[i].dest == head_info[j].dest)) begin
                        issue_blocked = 1'b1;
                    end
                end
                if (!issue_blocked) begin
                    issue_n = CNT_W'(j + 1);
                end
            end
        end
    end

    // Next-state for queue, fetch PC and issue registers; flush clears everything
    always_comb begin
        accept      = reset && !bus.flush && (count_q <= CNT_W'(DEPTH - WAYS));
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        fetch_pc_d  = fetch_pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        push_amt    = '0;
        pop_amt     = '0;
        if (bus.flush) begin
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            fetch_pc_d  = bus.redirect_pc;
            out_valid_d = '0;
            out_instr_d = '0;
            out_pc_d    = '0;
        end else begin
            if (accept) begin
                for (int k = 0; k < WAYS; k++) begin
                    instr_d[tail_q + PTR_W'(k)] = bus.fetch_bundle[32*k +: 32];
                    pc_d[tail_q + PTR_W'(k)]    = fetch_pc_q + 32'(4 * k);
                end
                tail_d     = tail_q + PTR_W'(WAYS);
                fetch_pc_d = fetch_pc_q + 32'(4 * WAYS);
                push_amt   = CNT_W'(WAYS);
            end
            if (!bus.stall) begin
                out_valid_d = '0;
                out_instr_d = '0;
                out_pc_d    = '0;
                for (int j = 0; j < WAYS; j++) begin
                    if (CNT_W'(j) < issue_n) begin
                        out_valid_d[j]          = 1'b1;
                        out_instr_d[32*j +: 32] = head_instr[j];
                        out_pc_d[32*j +: 32]    = head_pc[j];
                    end
                end
                head_d  = head_q + PTR_W'(issue_n);
                pop_amt = issue_n;
            end
            count_d = count_q + push_amt - pop_amt;
        end
    end

    // Control and issue registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            fetch_pc_q  <= '0;
            out_valid_q <= '0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            fetch_pc_q  <= fetch_pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

    // Queue storage is a plain register array; stale entries are never issued
    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        pc_q    <= pc_d;
    end

    assign bus.fetch_pc     = fetch_pc_q;
    assign bus.fetch_accept = accept;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_instr    = out_instr_q;
    assign bus.out_pc       = out_pc_q;
    assign bus.count        = count_q;
endmodule

// File: doc/issue_buffer_ss.md
ISSUE_BUFFER_SS -- requirements
Module: issue_buffer_ss

Interface
REQ-001 Parameter WAYS, default 2, meaning instructions fetched per bundle and maximum issued per cycle (1..4).
REQ-002 Parameter DEPTH, default 8, meaning queue entries; a power of two and at least 2*WAYS.
REQ-003 clk  input  1  rising-edge clock; sole clock.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 stall  input  1  downstream hold from hazard unit.
REQ-006 flush  input  1  pipeline redirect request.
REQ-007 redirect_pc  input  32  new fetch address, used when flush=1.
REQ-008 fetch_pc  output  32  address of the current fetch bundle to instruction memory.
REQ-009 fetch_bundle  input  32*WAYS  instructions at fetch_pc; slot k occupies bits [32k+31:32k]; combinational return.
REQ-010 fetch_accept  output  1  bundle captured this cycle.
REQ-011 out_valid  output  WAYS  per-slot issue valid.
REQ-012 out_instr  output  32*WAYS  issued instructions, slot order = program order.
REQ-013 out_pc  output  32*WAYS  PC of each issued instruction.
REQ-014 count  output  clog2(DEPTH+1)  queue occupancy.

Function
REQ-015 fetch_accept SHALL be 1 exactly when flush=0 and count <= DEPTH-WAYS, using pre-pop occupancy.
REQ-016 On accept, all WAYS instructions SHALL be written at the tail with PCs fetch_pc+4k, and fetch_pc SHALL advance by 4*WAYS.
REQ-017 Pointers SHALL wrap modulo DEPTH; push and pop in the same cycle SHALL both take effect.
REQ-018 Destination: opcode 0 -> bits[15:11]; opcodes 0x08-0x0F, 0x23 -> bits[20:16]; otherwise none; register 0 is never a destination.
REQ-019 Slot j SHALL depend on earlier slot i of the same group when dest(i) equals rs(j), rt(j) or dest(j).
REQ-020 Control transfers (opcodes 0x02-0x07; opcode 0 with funct 0x08/0x09) SHALL be the last instruction of their group.
REQ-021 Each cycle without stall or flush, issue count n SHALL be the longest head prefix, bounded by WAYS and count, that has no dependency and no slot after a control transfer; n entries pop.
REQ-022 Output registers SHALL load the n issued instructions into slots 0..n-1, with out_valid bits 0..n-1 = 1 and the remaining bits 0 with zero instr/pc.
REQ-023 Latency: a bundle accepted at edge e SHALL reach the outputs no earlier than edge e+1.
REQ-024 stall=1 (flush=0): outputs hold, no pop; fetch continues while space permits.
REQ-025 flush=1: priority over stall and fetch; at the edge, count=0, pointers=0, out_valid=0, out_instr/out_pc=0, fetch_pc=redirect_pc, no accept.
REQ-026 Empty queue with no stall: out_valid=0.

Reset
REQ-027 reset=0 at a rising edge SHALL set fetch_pc=0, count=0, pointers=0, out_valid=0, out_instr=0 and out_pc=0, overriding flush and stall, including mid-operation.
REQ-028 fetch_accept SHALL be 0 in any cycle where reset=0.

Structure
REQ-029 Opcode/funct constants, the destination/source field extraction and the control-transfer classification SHALL live in shared package issue_pkg_ss.
REQ-030 Per-slot decode (dest, rs, rt, is_ctrl) SHALL be one combinational sub-module, slot_decode_ss, instantiated WAYS times.
REQ-031 Queue storage SHALL be a register array; no memory macro.

Verification (WAYS=2, DEPTH=8)
REQ-032 Reset: hold reset=0 for 2 cycles -> fetch_pc=0, count=0, out_valid=2'b00, fetch_accept=0.
REQ-033 Independent pair: add $1,$2,$3 and add $4,$5,$6 at PC 0 -> out_valid=2'b11, out_pc={0x4,0x0}.
REQ-034 RAW split: add $1,$2,$3 then sub $4,$1,$5 -> cycle A out_valid=2'b01 (add); cycle A+1 out_valid=2'b01 (sub, pc 0x4).
REQ-035 Branch group end: beq in slot 0 followed by add -> beq issued alone; add issued next cycle.
REQ-036 Full/stall: stall=1 for 6 cycles -> count saturates at 8, fetch_accept=0, fetch_pc frozen at 0x20, outputs unchanged.
REQ-037 Flush: flush=1 with redirect_pc=0x40 while count=6 and stall=1 -> next cycle count=0, out_valid=0, fetch_pc=0x40; fetch resumes the following cycle.
